// File: rtl/fft_in_buffer.sv
// Ping-pong serial-to-parallel buffer feeding the 16-point FFT first stage.
// Optional sticky overflow flag is enabled by defining FFT_IN_BUF_OVF_EN.
module fft_in_buffer #(
    parameter int DW = 16,
    parameter int N  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [N*2*DW-1:0] frame_data,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              ovf
);

    localparam int WW = 2 * DW;
    localparam int CW = $clog2(N);

    logic [1:0][N*WW-1:0] bank_q;
    logic [1:0]           bank_full;
    logic                 wr_bank;
    logic                 rd_bank;
    logic [CW-1:0]        wr_cnt;
    logic                 wr_fire;
    logic                 rd_fire;
    logic                 wr_last;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // ready never depends on valid, and a producer holds data stable until it transfers.
    assign din_ready   = !rst && !bank_full[wr_bank];
    assign frame_valid = bank_full[rd_bank];
    assign frame_data  = bank_q[rd_bank];

    assign wr_fire = din_valid && din_ready;
    assign rd_fire = frame_valid && frame_ready;
    assign wr_last = (wr_cnt == CW'(N - 1));

    // Completion and release always target different banks: the write bank is
    // empty while the read bank is full, so both may update bank_full together.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q    <= '0;
            bank_full <= 2'b00;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_cnt    <= '0;
        end else begin
            if (wr_fire) begin
                bank_q[wr_bank][int'(wr_cnt)*WW +: WW] <= {din, {DW{1'b0}}};
                if (wr_last) begin
                    wr_cnt             <= '0;
                    bank_full[wr_bank] <= 1'b1;
                    wr_bank            <= ~wr_bank;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            if (rd_fire) begin
                bank_full[rd_bank] <= 1'b0;
                rd_bank            <= ~rd_bank;
            end
        end
    end

`ifdef FFT_IN_BUF_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (din_valid && !din_ready) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fft_in_buffer.sv
// Directed bench for fft_in_buffer: reset, single frame, ping-pong stall,
// simultaneous completion/release, mid-frame reset and continuous streaming.
module tb_fft_in_buffer;

    logic         clk;
    logic         rst;
    logic [15:0]  din;
    logic         din_valid;
    logic         din_ready;
    logic [511:0] frame_data;
    logic         frame_valid;
    logic         frame_ready;
    logic         ovf;

    int total = 0;
    int bad   = 0;
    logic [15:0]  exp_q[$];
    logic [511:0] exp_frame;
    logic [511:0] held;
    logic         exp_ovf;
    int           frames;

    fft_in_buffer #(.DW(16), .N(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .frame_data (frame_data),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] pop_frame();
        logic [511:0] f;
        f = '0;
        for (int k = 0; k < 16; k++) begin
            f[32*k +: 32] = {exp_q.pop_front(), 16'h0000};
        end
        return f;
    endfunction

    initial begin
`ifdef FFT_IN_BUF_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        // Reset held 2 cycles with din_valid asserted
        rst = 1'b1; din = 16'h1234; din_valid = 1'b1; frame_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_din_ready", 512'(din_ready), 512'(1'b0));
            chk("rst_frame_valid", 512'(frame_valid), 512'(1'b0));
            chk("rst_frame_data", frame_data, '0);
        end
        chk("rst_ovf", 512'(ovf), 512'(1'b0));
        rst = 1'b0; din_valid = 1'b0;
        tick();
        chk("post_rst_din_ready", 512'(din_ready), 512'(1'b1));
        chk("post_rst_frame_valid", 512'(frame_valid), 512'(1'b0));
        chk("post_rst_no_write", frame_data, '0);

        // Single frame 0x0100..0x1000
        for (int k = 0; k < 16; k++) begin
            din = 16'((k + 1) << 8); din_valid = 1'b1;
            tick();
            if (k == 14) chk("single_not_yet_valid", 512'(frame_valid), 512'(1'b0));
        end
        din_valid = 1'b0;
        exp_frame = '0;
        for (int k = 0; k < 16; k++) exp_frame[32*k +: 32] = {16'((k + 1) << 8), 16'h0000};
        chk("single_frame_valid", 512'(frame_valid), 512'(1'b1));
        chk("single_frame_data", frame_data, exp_frame);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("single_hold_data", frame_data, exp_frame);
        end
        chk("single_hold_valid", 512'(frame_valid), 512'(1'b1));
        chk("single_hold_din_ready", 512'(din_ready), 512'(1'b1));

        // Ping-pong stall: 40 samples, no consumer
        rst = 1'b1; tick(); rst = 1'b0;
        exp_q.delete();
        for (int i = 1; i <= 40; i++) begin
            din = 16'(i * 257); din_valid = 1'b1;
            #1;
            chk("pp_din_ready", 512'(din_ready), 512'(i <= 32));
            if (i <= 32) exp_q.push_back(16'(i * 257));
            tick();
        end
        din_valid = 1'b0;
        #1;
        chk("pp_full_din_ready", 512'(din_ready), 512'(1'b0));
        chk("pp_full_valid", 512'(frame_valid), 512'(1'b1));
        chk("pp_bank0_data", frame_data, pop_frame());
        chk("pp_ovf", 512'(ovf), 512'(exp_ovf));
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        chk("pp_after_rel_valid", 512'(frame_valid), 512'(1'b1));
        chk("pp_bank1_data", frame_data, pop_frame());
        chk("pp_after_rel_din_ready", 512'(din_ready), 512'(1'b1));
        chk("pp_ovf_sticky", 512'(ovf), 512'(exp_ovf));

        // Simultaneous completion into bank 1 and release of bank 0
        rst = 1'b1; tick(); rst = 1'b0;
        chk("sim_rst_ovf", 512'(ovf), 512'(1'b0));
        exp_q.delete();
        for (int i = 0; i < 31; i++) begin
            din = 16'(16'h2000 + i * 3); din_valid = 1'b1;
            exp_q.push_back(din);
            tick();
        end
        chk("sim_bank0_data", frame_data, pop_frame());
        din = 16'(16'h2000 + 31 * 3); exp_q.push_back(din);
        frame_ready = 1'b1;
        tick();
        din_valid = 1'b0; frame_ready = 1'b0;
        chk("sim_valid", 512'(frame_valid), 512'(1'b1));
        chk("sim_bank1_data", frame_data, pop_frame());
        chk("sim_din_ready", 512'(din_ready), 512'(1'b1));
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        chk("sim_drained_valid", 512'(frame_valid), 512'(1'b0));

        // Reset mid-frame discards partial samples
        for (int i = 0; i < 7; i++) begin
            din = 16'(16'h1111 * (i + 1)); din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_frame_data", frame_data, '0);
        for (int i = 0; i < 16; i++) begin
            din = 16'hFF00; din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        exp_frame = {16{32'hFF00_0000}};
        chk("midrst_valid", 512'(frame_valid), 512'(1'b1));
        chk("midrst_frame_data_ff00", frame_data, exp_frame);
        frame_ready = 1'b1;
        tick();
        chk("midrst_released", 512'(frame_valid), 512'(1'b0));

        // Continuous streaming with frame_ready held high
        exp_q.delete();
        frames = 0;
        for (int i = 0; i < 160; i++) begin
            din = 16'(i * 3 + 7); din_valid = 1'b1;
            #1;
            chk("stream_din_ready", 512'(din_ready), 512'(1'b1));
            exp_q.push_back(din);
            tick();
            if ((i % 16) == 15) begin
                frames++;
                chk("stream_frame_valid", 512'(frame_valid), 512'(1'b1));
                held = pop_frame();
                chk("stream_frame_data", frame_data, held);
            end
        end
        din_valid = 1'b0;
        chk("stream_frame_count", 512'(frames), 512'(10));
        tick();
        frame_ready = 1'b0;
        chk("stream_drained", 512'(frame_valid), 512'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
